// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default frame constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int OVERSAMPLE  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous write-side FIFO with registered full/empty flags
module uart_tx_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_wr;
    logic          do_rd;

    // Flags are the pre-edge view, so a pop never frees room for a same-cycle write.
    assign do_wr = wr_en && !full_q;
    assign do_rd = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - UART transmitter FSMD fed by a small byte FIFO
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_ONE   = 1;
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE   = 1;
    localparam logic [7:0]    D_MASK  = 8'((1 << DBIT) - 1);

    uart_state_e   state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          tx_q, tx_d;
    logic          rd_en;
    logic          done;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;

    uart_tx_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .din     (din),
        .rd_en   (rd_en),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d carries the line level of the state being entered, keeping tx edge-aligned with state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    b_d     = fifo_dout & D_MASK;
                    s_d     = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + N_ONE;
                            tx_d = b_q[1];
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SB_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for the buffered UART transmitter
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_en7 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] din7 = 8'h00;
    logic       full, tx, tx_busy, tx_done_tick;
    logic       full7, tx7, tx_busy7, tx_done_tick7;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_ph = 0;
    bit tick_fast = 1'b0;
    int done_cnt = 0;
    int n_gaps = 0;
    int bad_gaps = 0;
    int idle_run = 0;
    logic [7:0] exp_q[$];

    uart_tx_buffered dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    uart_tx_buffered #(
        .DBIT    (7),
        .SB_TICK (32),
        .FIFO_AW (2)
    ) dut7 (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .wr_en        (wr_en7),
        .din          (din7),
        .full         (full7),
        .tx           (tx7),
        .tx_busy      (tx_busy7),
        .tx_done_tick (tx_done_tick7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_ph = (tick_ph + 1) % 4;
            s_tick  = tick_fast || (tick_ph == 0);
        end
    end

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (!tx_busy) begin
            idle_run <= idle_run + 1;
        end else begin
            if (idle_run != 0) begin
                n_gaps <= n_gaps + 1;
                if (idle_run != 1) bad_gaps <= bad_gaps + 1;
            end
            idle_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit use7, input logic [7:0] v, output int at);
        if (use7) begin
            wr_en7 = 1'b1;
            din7   = v;
        end else begin
            wr_en = 1'b1;
            din   = v;
        end
        at = cyc;
        @(negedge clk);
        wr_en  = 1'b0;
        wr_en7 = 1'b0;
    endtask

    task automatic wait_fall(input bit use7, output int at);
        int t = 0;
        while ((use7 ? tx7 : tx) !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("fall_timeout", 32'(t < 3000), 32'd1);
        at = cyc;
    endtask

    task automatic wait_done(input bit use7, output int at);
        int t = 0;
        while (!(use7 ? tx_done_tick7 : tx_done_tick) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t < 3000), 32'd1);
        at = cyc;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((tx_busy || tx_busy7) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(t < 5000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Samples the line at the middle of each bit period, starting from the observed fall.
    task automatic capture(input bit use7, input int per, input int dbit, input int nstop,
                           output logic [7:0] data, output int fall_at);
        data = 8'h00;
        wait_fall(use7, fall_at);
        repeat (per / 2) @(negedge clk);
        chk("start_bit", use7 ? tx7 : tx, 32'd0);
        chk("busy_start", use7 ? tx_busy7 : tx_busy, 32'd1);
        for (int i = 0; i < dbit; i++) begin
            repeat (per) @(negedge clk);
            data[i] = use7 ? tx7 : tx;
        end
        chk("busy_data", use7 ? tx_busy7 : tx_busy, 32'd1);
        for (int j = 0; j < nstop; j++) begin
            repeat (per) @(negedge clk);
            chk("stop_bit", use7 ? tx7 : tx, 32'd1);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, got, e);
    endtask

    initial begin
        int t_wr, t_fall, t_done, d0, g0, b0, len;
        logic [7:0] d;
        logic [7:0] vals [5];

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 32'd1);
        chk("rst_busy", tx_busy, 32'd0);
        chk("rst_full", full, 32'd0);
        chk("rst_done", tx_done_tick, 32'd0);
        chk("rst_tx7", tx7, 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", tx, 32'd1);

        // single 0x55 frame, latency and done pulse
        d0 = done_cnt;
        exp_q.push_back(8'h55);
        wr(1'b0, 8'h55, t_wr);
        capture(1'b0, 64, 8, 1, d, t_fall);
        sb_check("t1_data", d);
        chk("t1_latency", 32'(t_fall - t_wr), 32'd2);
        wait_done(1'b0, t_done);
        len = t_done - t_fall + 1;
        chk("t1_frame_len", 32'(len >= 637 && len <= 640), 32'd1);
        repeat (4) @(negedge clk);
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        wait_idle();

        // burst of six writes: the first is popped while the second lands, so five fit
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) exp_q.push_back(8'(v));
            wr(1'b0, 8'(v), t_wr);
        end
        chk("t2_full", full, 32'd1);
        capture(1'b0, 64, 8, 1, d, t_fall);
        sb_check("t2_data", d);
        g0 = n_gaps;
        b0 = bad_gaps;
        for (int i = 0; i < 4; i++) begin
            capture(1'b0, 64, 8, 1, d, t_fall);
            sb_check("t2_data", d);
        end
        wait_done(1'b0, t_done);
        repeat (4) @(negedge clk);
        chk("t2_gaps", 32'(n_gaps - g0), 32'd4);
        chk("t2_gap_len", 32'(bad_gaps - b0), 32'd0);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_idle();

        // write while full in the pop cycle is dropped; write+pop at count 1 keeps count
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vals[i]);
            wr(1'b0, vals[i], t_wr);
        end
        chk("t5_full", full, 32'd1);
        chk("t5_cnt4", 32'(dut.u_fifo.count_q), 32'd4);
        capture(1'b0, 64, 8, 1, d, t_fall);
        sb_check("t5_data", d);
        wait_done(1'b0, t_done);
        @(negedge clk);
        chk("t5_full_pre_pop", full, 32'd1);
        wr(1'b0, 8'hF6, t_wr);
        chk("t5_cnt_full_pop", 32'(dut.u_fifo.count_q), 32'd3);
        chk("t5_full_after", full, 32'd0);
        for (int i = 0; i < 3; i++) begin
            capture(1'b0, 64, 8, 1, d, t_fall);
            sb_check("t5_data", d);
            wait_done(1'b0, t_done);
        end
        @(negedge clk);
        exp_q.push_back(8'h77);
        wr(1'b0, 8'h77, t_wr);
        chk("t5_cnt1_pop", 32'(dut.u_fifo.count_q), 32'd1);
        for (int i = 0; i < 2; i++) begin
            capture(1'b0, 64, 8, 1, d, t_fall);
            sb_check("t5_data", d);
        end
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_idle();

        // async reset during data bit 3 aborts the frame silently
        exp_q.push_back(8'hA5);
        wr(1'b0, 8'hA5, t_wr);
        wait_fall(1'b0, t_fall);
        repeat (32 + 64 * 4) @(negedge clk);
        chk("t4_bit3", tx, 32'd0);
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_tx", tx, 32'd1);
        chk("t4_rst_busy", tx_busy, 32'd0);
        chk("t4_rst_full", full, 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h3C);
        wr(1'b0, 8'h3C, t_wr);
        capture(1'b0, 64, 8, 1, d, t_fall);
        sb_check("t4_data", d);
        wait_idle();

        // DBIT=7, two stop bits: 0xFF sends seven ones, frame 160 ticks
        wr(1'b1, 8'hFF, t_wr);
        capture(1'b1, 64, 7, 2, d, t_fall);
        chk("t3_data", d, 32'h7F);
        wait_done(1'b1, t_done);
        len = t_done - t_fall + 1;
        chk("t3_frame_len", 32'(len >= 637 && len <= 640), 32'd1);
        wait_idle();

        // s_tick every clock: exact 160-clock frame
        tick_fast = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h55);
        wr(1'b0, 8'h55, t_wr);
        capture(1'b0, 16, 8, 1, d, t_fall);
        sb_check("t6_data", d);
        wait_done(1'b0, t_done);
        chk("t6_frame_len", 32'(t_done - t_fall + 1), 32'd160);
        tick_fast = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
